load_issue_scheduler: RTL and testbench

Picks which load-queue entry goes to the data cache next and runs the cache handshake for it. It scans the LQ's per-entry valid/address-ready state in age order, starting from the LQ head. It issues one load at a time, waits for the response, and replays the load after a miss. It sits between the load queue and the D-cache port, and reports completed loads back to the ROB/LQ.

---
 rtl/load_issue_scheduler_if.sv | 19 +
 rtl/load_issue_scheduler.sv | 155 +++++++++++++++
 tb/tb_load_issue_scheduler.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_issue_scheduler_if.sv
// D-cache request/response port between the load issue scheduler (master) and the cache (slave).
interface load_issue_scheduler_if #(
   parameter int ADDR_LEN = 32
);
   logic                dc_req_valid;
   logic                dc_req_ready;
   logic [ADDR_LEN-1:0] dc_req_addr;
   logic                dc_resp_valid;
   logic                dc_resp_hit;

   modport master (
      output dc_req_valid, dc_req_addr,
      input  dc_req_ready, dc_resp_valid, dc_resp_hit
   );
   modport slave (
      input  dc_req_valid, dc_req_addr,
      output dc_req_ready, dc_resp_valid, dc_resp_hit
   );
endinterface

// File: rtl/load_issue_scheduler.sv
// Age-ordered load picker: issues one LQ entry at a time to the D-cache,
// replays after a miss, and reports completed loads.
module load_issue_scheduler #(
   parameter int LQ_NUM     = 8,
   parameter int LQ_SEL     = 3,
   parameter int ADDR_LEN   = 32,
   parameter int ROB_SEL    = 6,
   parameter int REPLAY_DLY = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [LQ_NUM-1:0]            lq_valid,
   input  logic [LQ_NUM-1:0]            lq_addr_ready,
   input  logic [LQ_NUM*ADDR_LEN-1:0]   lq_addr_flat,
   input  logic [LQ_NUM*ROB_SEL-1:0]    lq_rob_flat,
   input  logic [LQ_SEL-1:0]            lq_head,
   input  logic                         flush,
   load_issue_scheduler_if.master       dc,
   output logic                         done_valid,
   output logic [LQ_SEL-1:0]            done_lq_idx,
   output logic [ROB_SEL-1:0]           done_rob_idx,
   output logic                         busy
);
   localparam int CNT_W = $clog2(REPLAY_DLY + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, REPLAY} state_e;

   state_e              state_q, state_d;
   logic [LQ_NUM-1:0]   issued_q, issued_d;
   logic [LQ_SEL-1:0]   sel_idx_q, sel_idx_d;
   logic [ADDR_LEN-1:0] sel_addr_q, sel_addr_d;
   logic [ROB_SEL-1:0]  sel_rob_q, sel_rob_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                done_q, done_d;
   logic [LQ_SEL-1:0]   done_idx_q, done_idx_d;
   logic [ROB_SEL-1:0]  done_rob_q, done_rob_d;

   logic [LQ_NUM-1:0]   elig;
   logic [LQ_NUM-1:0]   set_mask;
   logic                pick_vld;
   logic [LQ_SEL-1:0]   pick_idx;
   logic [LQ_SEL-1:0]   scan_idx;
   logic                sel_live;
   logic                accept;

   assign elig     = lq_valid & lq_addr_ready & ~issued_q;
   assign sel_live = lq_valid[sel_idx_q];

   assign dc.dc_req_valid = (state_q == REQ) && !flush;
   assign dc.dc_req_addr  = sel_addr_q;
   assign accept          = dc.dc_req_valid && dc.dc_req_ready;
   assign busy            = (state_q != IDLE);
   assign done_valid      = done_q && !flush;
   assign done_lq_idx     = done_idx_q;
   assign done_rob_idx    = done_rob_q;

   // Scan from youngest offset down so the entry closest to lq_head wins last.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      scan_idx = '0;
      for (int k = LQ_NUM - 1; k >= 0; k--) begin
         scan_idx = lq_head + LQ_SEL'(k);
         if (elig[scan_idx]) begin
            pick_vld = 1'b1;
            pick_idx = scan_idx;
         end
      end
   end

   always_comb begin
      set_mask = accept ? (LQ_NUM'(1) << sel_idx_q) : '0;
      issued_d = flush ? '0 : ((issued_q | set_mask) & lq_valid);
   end

   always_comb begin
      state_d    = state_q;
      sel_idx_d  = sel_idx_q;
      sel_addr_d = sel_addr_q;
      sel_rob_d  = sel_rob_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      done_idx_d = done_idx_q;
      done_rob_d = done_rob_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  state_d    = REQ;
                  sel_idx_d  = pick_idx;
                  sel_addr_d = lq_addr_flat[pick_idx*ADDR_LEN +: ADDR_LEN];
                  sel_rob_d  = lq_rob_flat[pick_idx*ROB_SEL +: ROB_SEL];
               end
            end
            REQ: begin
               if (!sel_live)   state_d = IDLE;
               else if (accept) state_d = WAIT;
            end
            WAIT: begin
               // A vanished entry abandons the load even if its response lands now.
               if (!sel_live) begin
                  state_d = IDLE;
               end else if (dc.dc_resp_valid) begin
                  if (dc.dc_resp_hit) begin
                     state_d    = IDLE;
                     done_d     = 1'b1;
                     done_idx_d = sel_idx_q;
                     done_rob_d = sel_rob_q;
                  end else begin
                     state_d = REPLAY;
                     cnt_d   = CNT_W'(REPLAY_DLY);
                  end
               end
            end
            REPLAY: begin
               if (!sel_live) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_d = REQ;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         issued_q   <= '0;
         sel_idx_q  <= '0;
         sel_addr_q <= '0;
         sel_rob_q  <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         done_idx_q <= '0;
         done_rob_q <= '0;
      end else begin
         state_q    <= state_d;
         issued_q   <= issued_d;
         sel_idx_q  <= sel_idx_d;
         sel_addr_q <= sel_addr_d;
         sel_rob_q  <= sel_rob_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         done_idx_q <= done_idx_d;
         done_rob_q <= done_rob_d;
      end
   end
endmodule

// File: tb/tb_load_issue_scheduler.sv
// Directed scenarios plus randomized rounds checked against an age-order completion model.
module tb_load_issue_scheduler;
   localparam int LQ_NUM     = 8;
   localparam int LQ_SEL     = 3;
   localparam int ADDR_LEN   = 32;
   localparam int ROB_SEL    = 6;
   localparam int REPLAY_DLY = 4;

   logic                       clk = 1'b0;
   logic                       reset;
   logic [LQ_NUM-1:0]          lq_valid;
   logic [LQ_NUM-1:0]          lq_addr_ready;
   logic [ADDR_LEN-1:0]        lq_addr [LQ_NUM];
   logic [ROB_SEL-1:0]         lq_rob  [LQ_NUM];
   logic [LQ_NUM*ADDR_LEN-1:0] lq_addr_flat;
   logic [LQ_NUM*ROB_SEL-1:0]  lq_rob_flat;
   logic [LQ_SEL-1:0]          lq_head;
   logic                       flush;
   logic                       done_valid;
   logic [LQ_SEL-1:0]          done_lq_idx;
   logic [ROB_SEL-1:0]         done_rob_idx;
   logic                       busy;

   int tests = 0;
   int fails = 0;

   load_issue_scheduler_if #(.ADDR_LEN(ADDR_LEN)) dcif ();

   load_issue_scheduler #(
      .LQ_NUM(LQ_NUM), .LQ_SEL(LQ_SEL), .ADDR_LEN(ADDR_LEN),
      .ROB_SEL(ROB_SEL), .REPLAY_DLY(REPLAY_DLY)
   ) dut (
      .clk(clk), .reset(reset),
      .lq_valid(lq_valid), .lq_addr_ready(lq_addr_ready),
      .lq_addr_flat(lq_addr_flat), .lq_rob_flat(lq_rob_flat),
      .lq_head(lq_head), .flush(flush),
      .dc(dcif.master),
      .done_valid(done_valid), .done_lq_idx(done_lq_idx),
      .done_rob_idx(done_rob_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      lq_addr_flat = '0;
      lq_rob_flat  = '0;
      for (int i = 0; i < LQ_NUM; i++) begin
         lq_addr_flat[i*ADDR_LEN +: ADDR_LEN] = lq_addr[i];
         lq_rob_flat[i*ROB_SEL +: ROB_SEL]    = lq_rob[i];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!dcif.dc_req_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_req"}, dcif.dc_req_valid, 1);
   endtask

   // One full cache transaction for entry idx with stall cycles and misses before the final hit.
   task automatic txn(input string tag, input int idx, input int stalls, input int nmiss);
      wait_req(tag);
      chk({tag, "_addr"}, dcif.dc_req_addr, lq_addr[idx]);
      for (int s = 0; s < stalls; s++) begin
         dcif.dc_req_ready = 1'b0;
         @(negedge clk);
         chk({tag, "_stall_vld"}, dcif.dc_req_valid, 1);
         chk({tag, "_stall_addr"}, dcif.dc_req_addr, lq_addr[idx]);
      end
      dcif.dc_req_ready = 1'b1;
      @(negedge clk);
      dcif.dc_req_ready = 1'b0;
      for (int m = 0; m <= nmiss; m++) begin
         dcif.dc_resp_valid = 1'b1;
         dcif.dc_resp_hit   = (m == nmiss);
         @(negedge clk);
         dcif.dc_resp_valid = 1'b0;
         dcif.dc_resp_hit   = 1'b0;
         if (m < nmiss) begin
            for (int c = 1; c <= REPLAY_DLY; c++) begin
               chk({tag, "_replay_quiet"}, dcif.dc_req_valid, 0);
               chk({tag, "_replay_nodone"}, done_valid, 0);
               @(negedge clk);
            end
            chk({tag, "_replay_req"}, dcif.dc_req_valid, 1);
            chk({tag, "_replay_addr"}, dcif.dc_req_addr, lq_addr[idx]);
            dcif.dc_req_ready = 1'b1;
            @(negedge clk);
            dcif.dc_req_ready = 1'b0;
         end
      end
      chk({tag, "_done"}, done_valid, 1);
      chk({tag, "_done_idx"}, done_lq_idx, idx);
      chk({tag, "_done_rob"}, done_rob_idx, lq_rob[idx]);
      chk({tag, "_busy"}, busy, 0);
      @(negedge clk);
      chk({tag, "_pulse"}, done_valid, 0);
   endtask

   initial begin
      int expq[$];
      bit pend, exp_done, miss_wait, finished, rv;
      int lat, miss_cyc, nmiss, quiet, ent;
      logic [ADDR_LEN-1:0] ra;

      reset = 1'b0; flush = 1'b0; lq_head = '0;
      lq_valid = '0; lq_addr_ready = '0;
      for (int i = 0; i < LQ_NUM; i++) begin
         lq_addr[i] = 32'h0000_0100 * (i + 1) + 32'h4;
         lq_rob[i]  = ROB_SEL'(i * 5 + 3);
      end
      dcif.dc_req_ready = 1'b0; dcif.dc_resp_valid = 1'b0; dcif.dc_resp_hit = 1'b0;
      #3;
      chk("rst_req", dcif.dc_req_valid, 0);
      chk("rst_addr", dcif.dc_req_addr, 0);
      chk("rst_done", done_valid, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      reset = 1'b1;

      // Ordering across the wrap: head 6, eligible 7 and 1; 0 and 6 valid but not ready.
      lq_head = 3'd6;
      lq_valid = 8'b1100_0011;
      lq_addr_ready = 8'b1000_0010;
      txn("ord7", 7, 0, 0);
      txn("ord1", 1, 0, 0);

      // Completed entries stay valid: nothing reissues until valid toggles.
      for (int c = 0; c < 10; c++) begin
         chk("noreissue_req", dcif.dc_req_valid, 0);
         chk("noreissue_busy", busy, 0);
         @(negedge clk);
      end
      lq_valid[7] = 1'b0;
      @(negedge clk);
      lq_valid[7] = 1'b1;
      txn("reissue7", 7, 0, 0);

      // Backpressure at 0x1000.
      lq_valid = '0;
      @(negedge clk);
      lq_head = '0;
      lq_addr[2] = 32'h0000_1000;
      lq_valid = 8'b0000_0100;
      lq_addr_ready = 8'b0000_0100;
      txn("bp", 2, 3, 0);
      chk("bp_addr_const", lq_addr[2], 32'h0000_1000);

      // Miss then replay.
      lq_valid = '0; @(negedge clk); lq_valid = 8'b0000_0100;
      txn("miss1", 2, 0, 1);
      lq_valid = '0; @(negedge clk); lq_valid = 8'b0000_0100;
      txn("miss2", 2, 1, 2);

      // Entry vanishes during replay: abandon, no completion.
      lq_valid = '0; @(negedge clk); lq_valid = 8'b0000_0100;
      wait_req("vanish");
      dcif.dc_req_ready = 1'b1; @(negedge clk); dcif.dc_req_ready = 1'b0;
      dcif.dc_resp_valid = 1'b1; dcif.dc_resp_hit = 1'b0;
      @(negedge clk);
      dcif.dc_resp_valid = 1'b0;
      lq_valid[2] = 1'b0;
      @(negedge clk);
      chk("vanish_busy", busy, 0);
      for (int c = 0; c < 6; c++) begin
         chk("vanish_req", dcif.dc_req_valid, 0);
         chk("vanish_done", done_valid, 0);
         @(negedge clk);
      end

      // Flush drops a pending request at once, then flush in WAIT with a late response.
      lq_valid = 8'b0000_0100;
      wait_req("flreq");
      flush = 1'b1;
      #1;
      chk("flreq_drop", dcif.dc_req_valid, 0);
      @(negedge clk);
      flush = 1'b0;
      wait_req("flwait");
      dcif.dc_req_ready = 1'b1; @(negedge clk); dcif.dc_req_ready = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flwait_busy", busy, 0);
      dcif.dc_resp_valid = 1'b1; dcif.dc_resp_hit = 1'b1;
      @(negedge clk);
      dcif.dc_resp_valid = 1'b0; dcif.dc_resp_hit = 1'b0;
      chk("flwait_nodone", done_valid, 0);
      chk("flwait_reissue", dcif.dc_req_valid, 1);
      txn("flredo", 2, 0, 0);

      // Async reset in REQ.
      lq_valid = '0; @(negedge clk); lq_valid = 8'b0000_0100;
      wait_req("arst");
      #2 reset = 1'b0;
      #1;
      chk("arst_req", dcif.dc_req_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done_valid, 0);
      @(negedge clk);
      reset = 1'b1;

      // Randomized rounds: eligible entries must complete once each in age order from head.
      for (int r = 0; r < 25; r++) begin
         lq_valid = '0; lq_addr_ready = '0;
         dcif.dc_req_ready = 1'b0; dcif.dc_resp_valid = 1'b0; dcif.dc_resp_hit = 1'b0;
         @(negedge clk);
         lq_head = LQ_SEL'($urandom);
         for (int i = 0; i < LQ_NUM; i++) begin
            lq_addr[i] = $urandom;
            lq_rob[i]  = ROB_SEL'($urandom);
         end
         lq_valid = LQ_NUM'($urandom);
         lq_addr_ready = LQ_NUM'($urandom);
         expq.delete();
         for (int k = 0; k < LQ_NUM; k++) begin
            ent = (int'(lq_head) + k) % LQ_NUM;
            if (lq_valid[ent] && lq_addr_ready[ent]) expq.push_back(ent);
         end
         pend = 0; exp_done = 0; miss_wait = 0; finished = 0;
         lat = 0; miss_cyc = 0; nmiss = 0; quiet = 0;
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rv = dcif.dc_req_valid;
            ra = dcif.dc_req_addr;
            if (exp_done) begin
               chk("rnd_done", done_valid, 1);
               chk("rnd_done_idx", done_lq_idx, expq[0]);
               chk("rnd_done_rob", done_rob_idx, lq_rob[expq[0]]);
               expq.pop_front();
               exp_done = 0;
            end else begin
               chk("rnd_nodone", done_valid, 0);
            end
            if (miss_wait && rv) begin
               chk("rnd_replay_gap", c - miss_cyc, REPLAY_DLY + 1);
               miss_wait = 0;
            end
            dcif.dc_resp_valid = 1'b0;
            dcif.dc_resp_hit   = 1'b0;
            if (pend) begin
               if (lat == 0) begin
                  pend = 0;
                  dcif.dc_resp_valid = 1'b1;
                  dcif.dc_resp_hit   = (nmiss >= 2) || ($urandom_range(0, 2) != 0);
                  if (dcif.dc_resp_hit) begin
                     exp_done = 1; nmiss = 0;
                  end else begin
                     miss_wait = 1; miss_cyc = c; nmiss++;
                  end
               end else begin
                  lat--;
               end
            end
            dcif.dc_req_ready = 1'($urandom_range(0, 1));
            if (rv && dcif.dc_req_ready) begin
               chk("rnd_req_expected", expq.size() != 0, 1);
               if (expq.size() != 0) chk("rnd_req_addr", ra, lq_addr[expq[0]]);
               pend = 1;
               lat = $urandom_range(0, 2);
            end
            if (expq.size() == 0 && !pend && !exp_done) begin
               chk("rnd_quiet", rv, 0);
               quiet++;
               if (quiet == 6) begin
                  finished = 1;
                  break;
               end
            end
         end
         chk("rnd_round_complete", finished, 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
